// File: rtl/ucie_ctl_phy_pkg.sv
// Shared types and defaults for the UCIe PHY control link-training launcher.
package ucie_ctl_phy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        REARM,
        CLEAR
    } train_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 4096;
    localparam int unsigned DEFAULT_MAX_RETRY      = 3;

endpackage

// File: rtl/ucie_ctl_phy_timeout_cnt.sv
// Saturating attempt timer; expire_o is high while the count sits at LIMIT-1.
module ucie_ctl_phy_timeout_cnt
    import ucie_ctl_phy_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(LIMIT + 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            expire_q;

    // Clear wins over count; stop at LIMIT so the timer never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntW'(LIMIT))) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= (cnt_d == CntW'(LIMIT - 1));
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/ucie_ctl_phy_train_launcher.sv
// Launches UCIe link training from the CSR start bit and reports the outcome.
// Optional retry-on-fail/timeout is enabled by defining UCIE_CTL_TRAIN_RETRY_EN.
module ucie_ctl_phy_train_launcher
    import ucie_ctl_phy_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRY      = DEFAULT_MAX_RETRY,
    parameter int unsigned RETRY_W        = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start_ucie_link_training,
    output logic               o_clear_start_training_bit,
    output logic               o_ltsm_train_req,
    input  logic               i_ltsm_train_ack,
    input  logic               i_ltsm_train_done,
    input  logic               i_ltsm_train_fail,
    output logic               o_link_up,
    output logic               o_train_busy,
    output logic               o_train_timeout,
    output logic [RETRY_W-1:0] o_retry_cnt
);

    if ((TIMEOUT_CYCLES < 2) || (MAX_RETRY < 1) || (MAX_RETRY >= (1 << RETRY_W))) begin : g_cfg_bad
        $error("ucie_ctl_phy_train_launcher: illegal TIMEOUT_CYCLES/MAX_RETRY/RETRY_W");
    end

    train_state_e state_q;
    logic         req_q;
    logic         busy_q;
    logic         link_up_q;
    logic         timeout_q;
    logic         clear_q;

    logic in_train;
    logic launch;
    logic att_fail;
    logic att_done;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_expire;
    logic go_rearm;

    assign in_train = (state_q == REQ) || (state_q == WAIT);
    assign launch   = (state_q == IDLE) && i_start_ucie_link_training;
    // Fail beats done; a real outcome on the expiry cycle beats the timeout.
    assign att_fail = in_train && (i_ltsm_train_fail || (tmr_expire && !i_ltsm_train_done));
    assign att_done = in_train && i_ltsm_train_done && !i_ltsm_train_fail;
    assign tmr_clr  = (state_q == IDLE) || (state_q == REARM);
    assign tmr_en   = in_train;

    ucie_ctl_phy_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

`ifdef UCIE_CTL_TRAIN_RETRY_EN
    logic [RETRY_W-1:0] retry_q;

    assign go_rearm = (retry_q < RETRY_W'(MAX_RETRY));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            retry_q <= '0;
        end else if (launch) begin
            retry_q <= '0;
        end else if (att_fail && go_rearm) begin
            retry_q <= retry_q + RETRY_W'(1);
        end
    end

    assign o_retry_cnt = retry_q;
`else
    assign go_rearm    = 1'b0;
    assign o_retry_cnt = '0;
`endif

    // Launch FSM with all status outputs registered alongside the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            link_up_q <= 1'b0;
            timeout_q <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q   <= REQ;
                        req_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        link_up_q <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                REQ, WAIT: begin
                    if (att_fail) begin
                        req_q  <= 1'b0;
                        busy_q <= 1'b0;
                        if (go_rearm) begin
                            state_q <= REARM;
                        end else begin
                            state_q   <= CLEAR;
                            clear_q   <= 1'b1;
                            link_up_q <= 1'b0;
                            timeout_q <= !i_ltsm_train_fail;
                        end
                    end else if (att_done) begin
                        state_q   <= CLEAR;
                        req_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        clear_q   <= 1'b1;
                        link_up_q <= 1'b1;
                    end else if ((state_q == REQ) && i_ltsm_train_ack) begin
                        state_q <= WAIT;
                        req_q   <= 1'b0;
                    end
                end
                REARM: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    busy_q  <= 1'b1;
                end
                CLEAR: begin
                    // A CSR write can re-set the start bit; keep the strobe until it reads 0.
                    if (!i_start_ucie_link_training) begin
                        state_q <= IDLE;
                        clear_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    clear_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_clear_start_training_bit = clear_q;
    assign o_ltsm_train_req           = req_q;
    assign o_link_up                  = link_up_q;
    assign o_train_busy               = busy_q;
    assign o_train_timeout            = timeout_q;

endmodule

// File: tb/tb_ucie_ctl_phy_train_launcher.sv
// Scoreboard bench for ucie_ctl_phy_train_launcher (TIMEOUT_CYCLES=16, MAX_RETRY=2).
module tb_ucie_ctl_phy_train_launcher;

    localparam int unsigned TO_CYC = 16;

    typedef struct packed {
        logic       link_up;
        logic       timeout;
        logic [1:0] retry;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       ack;
    logic       done;
    logic       fail;
    logic       clr;
    logic       req;
    logic       link_up;
    logic       busy;
    logic       tmo;
    logic [1:0] retry;

    int   total;
    int   bad;
    exp_t sb_q[$];

    ucie_ctl_phy_train_launcher #(
        .TIMEOUT_CYCLES (TO_CYC),
        .MAX_RETRY      (2),
        .RETRY_W        (2)
    ) dut (
        .i_clk                      (clk),
        .i_rst                      (rst),
        .i_start_ucie_link_training (start),
        .o_clear_start_training_bit (clr),
        .o_ltsm_train_req           (req),
        .i_ltsm_train_ack           (ack),
        .i_ltsm_train_done          (done),
        .i_ltsm_train_fail          (fail),
        .o_link_up                  (link_up),
        .o_train_busy               (busy),
        .o_train_timeout            (tmo),
        .o_retry_cnt                (retry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic d, input logic f, input logic a);
        done = d;
        fail = f;
        ack  = a;
        tick(1);
        done = 1'b0;
        fail = 1'b0;
        ack  = 1'b0;
    endtask

    task automatic launch(input exp_t e);
        sb_q.push_back(e);
        start = 1'b1;
    endtask

    task automatic release_start();
        start = 1'b0;
        tick(1);
        chk("clear_release", clr, 1'b0);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!req && (n < budget)) begin
            tick(1);
            n++;
        end
        chk("req_wait", req, 1'b1);
    endtask

    task automatic wait_clear(input int budget);
        int n = 0;
        while (!clr && (n < budget)) begin
            tick(1);
            n++;
        end
        chk("clear_wait", clr, 1'b1);
    endtask

    // Every rising clear strobe is one completed launch: pop and compare its outcome.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (clr && !prev) begin
                chk("sb_pending", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("sb_link_up", link_up, e.link_up);
                    chk("sb_timeout", tmo, e.timeout);
                    chk("sb_retry", retry, e.retry);
                end
            end
            prev = clr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        done  = 1'b0;
        fail  = 1'b0;
        tick(2);
        chk("rst_req", req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_link_up", link_up, 1'b0);
        chk("rst_clear", clr, 1'b0);
        chk("rst_timeout", tmo, 1'b0);
        chk("rst_retry", retry, 2'd0);
        rst = 1'b0;
        tick(1);

        // Normal launch: ack two cycles in, done five cycles after ack.
        launch('{link_up: 1'b1, timeout: 1'b0, retry: 2'd0});
        tick(1);
        chk("n_req1", req, 1'b1);
        chk("n_busy1", busy, 1'b1);
        tick(1);
        chk("n_req2", req, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("n_req_drop", req, 1'b0);
        chk("n_busy_wait", busy, 1'b1);
        tick(4);
        pulse(1'b1, 1'b0, 1'b0);
        chk("n_link_up", link_up, 1'b1);
        chk("n_busy_clr", busy, 1'b0);
        chk("n_clear", clr, 1'b1);
        // Start bit held high (masked clear) plus stray late LTSM pulses.
        tick(2);
        pulse(1'b0, 1'b1, 1'b1);
        chk("n_clear_held", clr, 1'b1);
        chk("n_late_ignored", link_up, 1'b1);
        chk("n_no_relaunch", req, 1'b0);
        release_start();
        chk("n_link_up_idle", link_up, 1'b1);

        // Done while still in REQ acts as ack plus outcome.
        launch('{link_up: 1'b1, timeout: 1'b0, retry: 2'd0});
        tick(1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("dreq_clear", clr, 1'b1);
        chk("dreq_link_up", link_up, 1'b1);
        release_start();

`ifndef UCIE_CTL_TRAIN_RETRY_EN
        // Timeout: no ack/done; flag appears exactly TO_CYC cycles after REQ entry.
        launch('{link_up: 1'b0, timeout: 1'b1, retry: 2'd0});
        tick(1);
        chk("to_busy", busy, 1'b1);
        tick(TO_CYC - 1);
        chk("to_early", tmo, 1'b0);
        chk("to_busy_late", busy, 1'b1);
        tick(1);
        chk("to_flag", tmo, 1'b1);
        chk("to_clear", clr, 1'b1);
        chk("to_link_up", link_up, 1'b0);
        chk("to_retry", retry, 2'd0);
        release_start();

        // Done and fail together: fail wins.
        launch('{link_up: 1'b0, timeout: 1'b0, retry: 2'd0});
        tick(1);
        chk("col_to_cleared", tmo, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        tick(1);
        pulse(1'b1, 1'b1, 1'b0);
        chk("col_link_up", link_up, 1'b0);
        chk("col_clear", clr, 1'b1);
        release_start();
`endif

        // Done on the expiry cycle beats the timeout.
        launch('{link_up: 1'b1, timeout: 1'b0, retry: 2'd0});
        tick(1);
        pulse(1'b0, 1'b0, 1'b1);
        tick(TO_CYC - 2);
        pulse(1'b1, 1'b0, 1'b0);
        chk("edge_link_up", link_up, 1'b1);
        chk("edge_timeout", tmo, 1'b0);
        chk("edge_clear", clr, 1'b1);

        // CSR drops the bit for one cycle, then rewrites it: relaunch only from IDLE.
        start = 1'b0;
        tick(1);
        chk("rel_clear_low", clr, 1'b0);
        chk("rel_idle_req", req, 1'b0);
        launch('{link_up: 1'b1, timeout: 1'b0, retry: 2'd0});
        tick(1);
        chk("rel_req", req, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        release_start();

        // Async reset during WAIT aborts; start still high relaunches.
        start = 1'b1;
        tick(1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("rw_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rw_req", req, 1'b0);
        chk("rw_busy0", busy, 1'b0);
        chk("rw_link_up", link_up, 1'b0);
        tick(1);
        rst = 1'b0;
        sb_q.push_back('{link_up: 1'b1, timeout: 1'b0, retry: 2'd0});
        tick(1);
        chk("rw_relaunch", req, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        release_start();

`ifdef UCIE_CTL_TRAIN_RETRY_EN
        // Fail, fail, done: two retries consumed, link up.
        launch('{link_up: 1'b1, timeout: 1'b0, retry: 2'd2});
        tick(1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("r_retry1", retry, 2'd1);
        chk("r_rearm_req", req, 1'b0);
        chk("r_rearm_noclr", clr, 1'b0);
        wait_req(4);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("r_retry2", retry, 2'd2);
        wait_req(4);
        pulse(1'b1, 1'b0, 1'b0);
        chk("r_link_up", link_up, 1'b1);
        release_start();

        // Three timeouts: only the last one raises the flag.
        launch('{link_up: 1'b0, timeout: 1'b1, retry: 2'd2});
        tick(1);
        tick(TO_CYC);
        chk("rt_no_flag", tmo, 1'b0);
        chk("rt_retry1", retry, 2'd1);
        wait_clear(3 * TO_CYC + 8);
        chk("rt_flag", tmo, 1'b1);
        release_start();
`endif

        tick(3);
        chk("sb_drain", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
